// File: rtl/packet_scheduler_pkg.sv
// packet_scheduler_pkg: shared types and default timing constants for the serial link scheduler
package packet_scheduler_pkg;
  typedef enum logic {PKT_DATA, PKT_ACK} pkt_type_t;
  typedef enum logic [2:0] {IDLE, SEND_ACK, SEND_DATA, WAIT_ACK, LINK_FAIL} sched_state_t;
  localparam int DEFAULT_TIMEOUT_CYCLES = 500000;
  localparam int DEFAULT_MAX_RETRIES = 7;
endpackage

// File: rtl/packet_scheduler_if.sv
// packet_scheduler_if: signals between game logic, receiver, sender and the scheduler
interface packet_scheduler_if;
  import packet_scheduler_pkg::*;
  logic game_active;
  logic data_req;
  logic send_ready_ACK;
  logic rx_seqNum;
  logic ack_received;
  logic ack_seqNum;
  logic sender_done;
  logic send_start;
  pkt_type_t send_type;
  logic send_seqNum;
  logic busy;
  logic link_error;
  logic [3:0] data_sent_cnt;
  logic [3:0] retry_cnt;
  modport master (
    input game_active, data_req, send_ready_ACK, rx_seqNum, ack_received, ack_seqNum, sender_done,
    output send_start, send_type, send_seqNum, busy, link_error, data_sent_cnt, retry_cnt
  );
  modport slave (
    output game_active, data_req, send_ready_ACK, rx_seqNum, ack_received, ack_seqNum, sender_done,
    input send_start, send_type, send_seqNum, busy, link_error, data_sent_cnt, retry_cnt
  );
endinterface

// File: rtl/packet_scheduler_ack_timer.sv
// ack_timer: saturating ACK wait timer plus retransmission counter
module ack_timer
  import packet_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES = DEFAULT_MAX_RETRIES
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       clear,
  input  logic       enable,
  input  logic       hold,
  input  logic       retry_clear,
  input  logic       retry_inc,
  output logic       expired,
  output logic [3:0] retry_cnt,
  output logic       retries_exhausted
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] timer;
  // Timer counts only while enabled and not held, and sticks at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) timer <= '0;
    else if (clear) timer <= '0;
    else if (enable && !hold && timer != '1) timer <= timer + 1'b1;
  // Retransmissions of the packet currently awaiting its ACK
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) retry_cnt <= '0;
    else if (retry_clear) retry_cnt <= '0;
    else if (retry_inc) retry_cnt <= retry_cnt + 4'd1;
  // >= so a timeout that coincides with an ACK launch still fires after the ACK goes out
  assign expired = timer >= LAST;
  assign retries_exhausted = retry_cnt >= 4'(MAX_RETRIES);
endmodule

// File: rtl/packet_scheduler.sv
// packet_scheduler: stop-and-wait sequencing of ACK and DATA packets onto the single serial sender
module packet_scheduler
  import packet_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES = DEFAULT_MAX_RETRIES
) (
  input logic clk,
  input logic rst_l,
  packet_scheduler_if.master link
);
  sched_state_t state, state_n;
  pkt_type_t ptype, ptype_n;
  logic ack_pend, ack_pend_n, ack_seq, ack_seq_n, data_pend, data_pend_n;
  logic outstanding, outstanding_n, tx_seq, tx_seq_n;
  logic start, start_n, seq, seq_n, busy, busy_n, link_error, link_error_n;
  logic [3:0] sent_cnt, sent_cnt_n, retry_cnt;
  logic match, flush, launch_ack, launch_data, retry, expired, exhausted;
  ack_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .MAX_RETRIES(MAX_RETRIES)) u_timer (
    .clk(clk),
    .rst_l(rst_l),
    .clear(flush | launch_data | retry | (state == SEND_DATA)),
    .enable(outstanding),
    .hold(state != WAIT_ACK),
    .retry_clear(flush | launch_data | match),
    .retry_inc(retry),
    .expired(expired),
    .retry_cnt(retry_cnt),
    .retries_exhausted(exhausted)
  );
  // State, pending flags and registered outputs
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      state       <= IDLE;
      ack_pend    <= 1'b0;
      ack_seq     <= 1'b0;
      data_pend   <= 1'b0;
      outstanding <= 1'b0;
      tx_seq      <= 1'b0;
      start       <= 1'b0;
      ptype       <= PKT_DATA;
      seq         <= 1'b0;
      busy        <= 1'b0;
      link_error  <= 1'b0;
      sent_cnt    <= '0;
    end else begin
      state       <= state_n;
      ack_pend    <= ack_pend_n;
      ack_seq     <= ack_seq_n;
      data_pend   <= data_pend_n;
      outstanding <= outstanding_n;
      tx_seq      <= tx_seq_n;
      start       <= start_n;
      ptype       <= ptype_n;
      seq         <= seq_n;
      busy        <= busy_n;
      link_error  <= link_error_n;
      sent_cnt    <= sent_cnt_n;
    end
  // Launch decisions and next values; a matching ACK is honoured in every state
  always_comb begin
    state_n     = state;
    flush       = 1'b0;
    launch_ack  = 1'b0;
    launch_data = 1'b0;
    retry       = 1'b0;
    match       = link.ack_received && (link.ack_seqNum == tx_seq) && outstanding;
    case (state)
      IDLE:
        if (!link.game_active) flush = 1'b1;
        else if (ack_pend) begin
          launch_ack = 1'b1;
          state_n    = SEND_ACK;
        end else if (data_pend) begin
          launch_data = 1'b1;
          state_n     = SEND_DATA;
        end
      SEND_ACK, SEND_DATA:
        if (link.sender_done) begin
          flush   = !link.game_active;
          state_n = (link.game_active && outstanding && !match) ? WAIT_ACK : IDLE;
        end
      WAIT_ACK:
        if (!link.game_active) begin
          flush   = 1'b1;
          state_n = IDLE;
        end else if (ack_pend) begin
          launch_ack = 1'b1;
          state_n    = SEND_ACK;
        end else if (match) state_n = IDLE;
        else if (expired) begin
          retry   = !exhausted;
          state_n = exhausted ? LINK_FAIL : SEND_DATA;
        end
      LINK_FAIL:
        if (!link.game_active) begin
          flush   = 1'b1;
          state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
    ack_pend_n    = !flush && ((ack_pend && !launch_ack) || link.send_ready_ACK);
    ack_seq_n     = link.send_ready_ACK ? link.rx_seqNum : ack_seq;
    data_pend_n   = !flush && ((data_pend && !launch_data) || link.data_req);
    outstanding_n = !flush && (launch_data || (outstanding && !match));
    tx_seq_n      = !flush && (tx_seq ^ match);
    start_n       = launch_ack || launch_data || retry;
    ptype_n       = launch_ack ? PKT_ACK : (launch_data || retry) ? PKT_DATA : ptype;
    seq_n         = launch_ack ? ack_seq : (launch_data || retry) ? tx_seq : seq;
    sent_cnt_n    = sent_cnt + {3'b000, launch_data};
    busy_n        = (state_n == SEND_ACK) || (state_n == SEND_DATA) || outstanding_n;
    link_error_n  = state_n == LINK_FAIL;
  end
  assign link.send_start    = start;
  assign link.send_type     = ptype;
  assign link.send_seqNum   = seq;
  assign link.busy          = busy;
  assign link.link_error    = link_error;
  assign link.data_sent_cnt = sent_cnt;
  assign link.retry_cnt     = retry_cnt;
endmodule

// File: doc/packet_scheduler.md
# packet_scheduler

Sequencing controller for the inter-board serial link. It owns the single serial transmitter (Sender) and decides what it transmits next: ACKs owed to the opponent for packets the Receiver has accepted, or our own game-state data packets. It enforces stop-and-wait delivery with a 1-bit alternating sequence number, timeout-driven retransmission, and a link-failure flag. It sits between the game logic, the Receiver, and the Sender.

## Interface
- TIMEOUT_CYCLES, 500000: clk cycles to wait for a matching ACK (10 ms at 50 MHz).
- MAX_RETRIES, 7: retransmissions allowed before declaring link failure.
- clk  input  1  system clock (CLOCK_50 domain). The single clock.
- rst_l  input  1  reset, asynchronous, active-low.
- game_active  input  1  link enable; low flushes state.
- data_req  input  1  1-cycle pulse: new local game state ready to send.
- send_ready_ACK  input  1  1-cycle pulse from Receiver: opponent packet accepted, ACK owed.
- rx_seqNum  input  1  sequence number to ACK, valid with send_ready_ACK.
- ack_received  input  1  1-cycle pulse from Receiver: ACK packet arrived.
- ack_seqNum  input  1  sequence number carried by that ACK.
- sender_done  input  1  1-cycle pulse: Sender finished the current packet.
- send_start  output  1  1-cycle pulse: Sender begins a packet.
- send_type  output  pkt_type_t  PKT_DATA or PKT_ACK, stable from send_start until sender_done.
- send_seqNum  output  1  sequence number for the packet, stable with send_type.
- busy  output  1  a packet is in flight, or a data ACK is outstanding.
- link_error  output  1  sticky: MAX_RETRIES exhausted.
- data_sent_cnt  output  4  data packets first-sent (not retries), wraps 15→0.
- retry_cnt  output  4  retries of the current outstanding packet.

## Operation
- States: IDLE, SEND_ACK, SEND_DATA, WAIT_ACK, LINK_FAIL.
- Pending flags:
  - ack_pend is set by send_ready_ACK, which also latches rx_seqNum. A second request while pending overwrites the seqNum. ack_pend clears when the ACK is launched.
  - data_pend is set by data_req and cleared on the first launch of that data packet. A data_req while data is outstanding stays pending.
- IDLE, game_active=1:
  - If ack_pend: launch ACK, go to SEND_ACK. ACK has priority.
  - Else if data_pend: launch DATA with send_seqNum=tx_seq, set outstanding, clear timer and retry_cnt, increment data_sent_cnt, go to SEND_DATA.
- SEND_ACK: on sender_done, go to WAIT_ACK if outstanding, else IDLE.
- SEND_DATA: on sender_done, go to IDLE if outstanding has already cleared, else WAIT_ACK with timer=0.
- WAIT_ACK:
  - Timer increments each cycle.
  - If ack_pend: launch ACK, go to SEND_ACK. The timer holds (does not reset) while in SEND_ACK.
  - If timer reaches TIMEOUT_CYCLES-1:
    - If retry_cnt==MAX_RETRIES: go to LINK_FAIL.
    - Else: retry_cnt+1, relaunch DATA with the same seqNum, go to SEND_DATA.
- ACK matching:
  - An ack_received with ack_seqNum==tx_seq while outstanding: clear outstanding, toggle tx_seq, zero retry_cnt. This applies in any state.
  - In WAIT_ACK it goes to IDLE the next cycle.
  - A mismatched or unsolicited ACK is ignored.
- Simultaneous events in WAIT_ACK:
  - Matching ACK and timeout in the same cycle: the ACK wins, no retransmit.
  - Matching ACK and ack_pend in the same cycle: clear outstanding and launch the ACK.
- LINK_FAIL: link_error=1, send_start is never asserted, pending flags still accumulate. Exits only on reset or game_active=0.
- game_active=0:
  - In IDLE, WAIT_ACK or LINK_FAIL: go to IDLE the next cycle; clear ack_pend, data_pend, outstanding, tx_seq, retry_cnt, timer and link_error. data_sent_cnt is kept.
  - In SEND_*: finish the packet (wait for sender_done), then apply the flush.

## Timing
- Reset: state IDLE; all outputs 0; send_type=PKT_DATA; tx_seq=0; counters and flags 0.
- All outputs are registered.
- send_start asserts in the cycle after the launch decision, i.e. 2 cycles after a data_req/send_ready_ACK pulse seen in IDLE.
- send_start is never asserted while in SEND_*; at most one packet is in flight.
- sender_done received in the same cycle as send_start is illegal. Sender guarantees ≥1 cycle gap.
- Timeout-to-retransmit: send_start asserts 1 cycle after the timer hits TIMEOUT_CYCLES-1.
- Timer width: $clog2(TIMEOUT_CYCLES). It saturates and never wraps.

## Structure
- NetworkPkg gets:
  - pkt_type_t {PKT_DATA, PKT_ACK}
  - sched_state_t
  - constants DEFAULT_TIMEOUT_CYCLES and DEFAULT_MAX_RETRIES
- One sub-module, ack_timer:
  - Inputs: clear, enable, hold.
  - Outputs: expired, plus retry counter with retries_exhausted.
- The FSM and pending flags stay in packet_scheduler.

## Test plan
- Basic data send: data_req, then sender_done 20 cycles later, then ack_received with seqNum 0 → one send_start with PKT_DATA seq 0; busy falls; tx_seq=1; data_sent_cnt=1.
- ACK priority: send_ready_ACK(rx_seqNum=1) and data_req in the same cycle → first send_start is PKT_ACK seq 1; after sender_done, the next send_start is PKT_DATA seq 0.
- Timeout and retry, with TIMEOUT_CYCLES=100 and no ACK:
  - Retransmits every 100 cycles after each sender_done, with seq unchanged and retry_cnt 1..7.
  - The 8th timeout sets link_error.
  - game_active=0 clears it.
- Mismatched ACK: ack_received with seqNum 1 while waiting on 0 → no state change; the retransmit still occurs at timeout.
- ACK interleave in WAIT_ACK:
  - send_ready_ACK at timer=50 (TIMEOUT_CYCLES=100): the ACK is sent and the timer holds for the ACK's duration.
  - With no matching ACK, the retransmit occurs at wait-cycle 100, not counting cycles spent in SEND_ACK.
- Mid-operation reset: rst_l low during SEND_DATA → all outputs 0 asynchronously; after release, the FSM is in IDLE with no send_start.
